// File: rtl/seq_alu_if.sv
// Operand/result bundle between the issue logic and the registered ALU.
// The master drives the request and operands; the slave returns the result and flags.
interface seq_alu_if #(
  parameter int n = 64
);
  logic         Start;
  logic [3:0]   ALUCtrl;
  logic [n-1:0] BusA;
  logic [n-1:0] BusB;
  logic [n-1:0] BusW;
  logic         Done;
  logic         Busy;
  logic         Zero;
  logic         Negative;
  logic         Carry;
  logic         Overflow;

  modport master (
    output Start, ALUCtrl, BusA, BusB,
    input  BusW, Done, Busy, Zero, Negative, Carry, Overflow
  );

  modport slave (
    input  Start, ALUCtrl, BusA, BusB,
    output BusW, Done, Busy, Zero, Negative, Carry, Overflow
  );
endinterface

// File: rtl/seq_alu.sv
// Registered n-bit ALU with N/Z/C/V flags and a Start/Busy/Done handshake.
// Single-cycle ops retire on the capturing edge; MUL runs n shift-add steps.
module seq_alu #(
  parameter int n = 64
) (
  input  logic     CLK,
  input  logic     Resetb,
  seq_alu_if.slave bus
);
  localparam int SW = $clog2(n);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_LSL   = 4'b0011;
  localparam logic [3:0] OP_LSR   = 4'b0100;
  localparam logic [3:0] OP_ASR   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  typedef struct packed {
    logic [n-1:0] res;
    logic         carry;
    logic         ovf;
  } aluOut_t;

  // Any set bit above the low SW bits means the amount is at least n.
  function automatic logic bigShift(input logic [n-1:0] amt);
    return |amt[n-1:SW];
  endfunction

  function automatic logic [n-1:0] shiftLeft(input logic [n-1:0] a, input logic [n-1:0] amt);
    return bigShift(amt) ? '0 : (a << amt[SW-1:0]);
  endfunction

  function automatic logic [n-1:0] shiftRightLogic(input logic [n-1:0] a, input logic [n-1:0] amt);
    return bigShift(amt) ? '0 : (a >> amt[SW-1:0]);
  endfunction

  function automatic logic [n-1:0] shiftRightArith(input logic [n-1:0] a, input logic [n-1:0] amt);
    logic signed [n-1:0] sA;
    logic signed [n-1:0] sR;
    sA = a;
    sR = sA >>> amt[SW-1:0];
    return bigShift(amt) ? {n{a[n-1]}} : sR;
  endfunction

  // SUB is A + ~B + 1, so Carry set means no borrow.
  function automatic aluOut_t addSub(input logic [n-1:0] a, input logic [n-1:0] b, input logic sub);
    aluOut_t             o;
    logic [n-1:0]        bOp;
    logic [n:0]          sum;
    logic signed [n-1:0] sA;
    logic signed [n-1:0] sB;
    logic signed [n-1:0] sS;
    bOp     = sub ? ~b : b;
    sum     = {1'b0, a} + {1'b0, bOp} + {{n{1'b0}}, sub};
    sA      = a;
    sB      = bOp;
    sS      = sum[n-1:0];
    o.res   = sum[n-1:0];
    o.carry = sum[n];
    o.ovf   = ((sA < 0) == (sB < 0)) && ((sS < 0) != (sA < 0));
    return o;
  endfunction

  function automatic aluOut_t aluOp(input logic [3:0] op, input logic [n-1:0] a, input logic [n-1:0] b);
    aluOut_t o;
    o = '0;
    case (op)
      OP_AND:   o.res = a & b;
      OP_OR:    o.res = a | b;
      OP_ADD:   o     = addSub(a, b, 1'b0);
      OP_LSL:   o.res = shiftLeft(a, b);
      OP_LSR:   o.res = shiftRightLogic(a, b);
      OP_ASR:   o.res = shiftRightArith(a, b);
      OP_SUB:   o     = addSub(a, b, 1'b1);
      OP_PASSB: o.res = b;
      default:  o     = '0;
    endcase
    return o;
  endfunction

  state_t        state;
  state_t        nextState;
  logic [SW-1:0] cnt;
  logic          loadOne;
  logic          loadMul;
  logic          mulLast;
  aluOut_t       oneOut;

  logic [n-1:0]  mcand;
  logic [n-1:0]  mplier;
  logic [n-1:0]  acc;
  logic [n-1:0]  accNext;

  logic [n-1:0]  result_p1;
  logic          done_p1;
  logic          zero_p1;
  logic          neg_p1;
  logic          carry_p1;
  logic          ovf_p1;

  assign oneOut  = aluOp(bus.ALUCtrl, bus.BusA, bus.BusB);
  assign accNext = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    nextState = state;
    loadOne   = 1'b0;
    loadMul   = 1'b0;
    mulLast   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Start) begin
          if (bus.ALUCtrl == OP_MUL) begin
            loadMul   = 1'b1;
            nextState = MUL;
          end else begin
            loadOne = 1'b1;
          end
        end
      end
      MUL: begin
        if (cnt == SW'(n - 1)) begin
          mulLast   = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Resetb) begin
    if (!Resetb) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      if (loadMul) begin
        cnt <= '0;
      end else if (state == MUL) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Multiply datapath: multiplicand walks left, multiplier walks right,
  // so the product is naturally truncated to n bits.
  always_ff @(posedge CLK) begin
    if (loadMul) begin
      mcand  <= bus.BusA;
      mplier <= bus.BusB;
      acc    <= '0;
    end else if (state == MUL) begin
      acc    <= accNext;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // Stage p1: result/flag register, written only on completion.
  always_ff @(posedge CLK or negedge Resetb) begin
    if (!Resetb) begin
      result_p1 <= '0;
      done_p1   <= 1'b0;
      zero_p1   <= 1'b1;
      neg_p1    <= 1'b0;
      carry_p1  <= 1'b0;
      ovf_p1    <= 1'b0;
    end else begin
      done_p1 <= loadOne | mulLast;
      if (loadOne) begin
        result_p1 <= oneOut.res;
        zero_p1   <= (oneOut.res == '0);
        neg_p1    <= oneOut.res[n-1];
        carry_p1  <= oneOut.carry;
        ovf_p1    <= oneOut.ovf;
      end else if (mulLast) begin
        result_p1 <= accNext;
        zero_p1   <= (accNext == '0);
        neg_p1    <= accNext[n-1];
        carry_p1  <= 1'b0;
        ovf_p1    <= 1'b0;
      end
    end
  end

  assign bus.BusW     = result_p1;
  assign bus.Done     = done_p1;
  assign bus.Busy     = (state == MUL);
  assign bus.Zero     = zero_p1;
  assign bus.Negative = neg_p1;
  assign bus.Carry    = carry_p1;
  assign bus.Overflow = ovf_p1;
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, registered successor to the processor's combinational 64-bit ALU.
- Keeps the existing 4-bit ALUCtrl encodings and adds arithmetic shift right and an iterative shift-add multiply.
- Adds a full N/Z/C/V flag set.
- Uses a Start/Busy/Done handshake so the multi-cycle datapath can stall on long operations.
- Sits between the register file / immediate mux and the writeback / branch logic.

Parameters:
- n, 64, operand and result width in bits (at least 8, a power of 2).
- SW, clog2(n), derived only (not user-overridable): width of the multiply iteration counter.

Ports:
- CLK  input  1  rising-edge clock.
- Resetb  input  1  reset, asynchronous assert, active-low.
- Start  input  1  request; sampled only in IDLE.
- ALUCtrl  input  4  operation code.
- BusA  input  n  operand A.
- BusB  input  n  operand B / shift amount.
- BusW  output  n  registered result.
- Done  output  1  one-cycle pulse: BusW and flags updated this cycle.
- Busy  output  1  high while a multiply is iterating.
- Zero  output  1  BusW == 0.
- Negative  output  1  BusW[n-1].
- Carry  output  1  carry flag.
- Overflow  output  1  signed overflow flag.

Behaviour:
- Clock, reset and polarity (decided): one clock, CLK. Reset is asynchronous and active-low on Resetb.
- Reset values:
  - BusW=0, Zero=1, all other outputs 0, FSM to IDLE.
  - Reset asserted mid-multiply aborts it; no Done is issued.
- Operation codes:
  - AND 0000, OR 0001, ADD 0010, LSL 0011, LSR 0100, ASR 0101, SUB 0110, PassB 0111, MUL 1000.
  - Any other code gives result 0 and still completes in one cycle with Done.
- Operand capture:
  - BusA, BusB and ALUCtrl are captured on the edge where IDLE && Start.
  - Inputs may change freely afterwards.
- States: IDLE, MUL. Done is a registered pulse, not a state.
- IDLE transitions:
  - Start with a non-MUL code: the result and flags are written on the same edge. Done=1 for exactly the following cycle. Busy stays 0 and the state stays IDLE.
  - Back-to-back single-cycle starts are legal: one result per cycle, with Done held high while Start is held.
  - Start with MUL: go to MUL, Busy=1, counter=0. The accumulator is cleared; multiplicand and multiplier are loaded from BusA and BusB.
- MUL state:
  - One shift-add step per cycle, n steps in total.
  - On the edge completing step n-1: BusW = low n bits of the product; flags are updated; Done=1 for one cycle; Busy=0; return to IDLE.
  - Total latency: n cycles from the capturing edge. The product is unsigned and truncated; the upper half is discarded.
- Start while Busy is ignored: not queued, no effect.
- Shifts:
  - The amount is the full unsigned BusB.
  - Amount >= n: LSL/LSR give 0; ASR gives all copies of BusA[n-1].
  - Amount 0 passes BusA through.
- Flags (all written only when Done is set; otherwise they hold):
  - Zero and Negative always reflect the new BusW.
  - ADD: Carry = carry out of bit n-1.
  - SUB: computed as A + ~B + 1; Carry = carry out (1 means no borrow).
  - Overflow on ADD/SUB = signed overflow of that sum.
  - All other ops: Carry=0, Overflow=0.
- BusW holds its last value until the next completion.

Test Plan:
- Reset: Resetb=0 with Start=1 → BusW=0, Zero=1, Done=0, Busy=0. Release, then start ADD A=5, B=7 → next cycle BusW=12, Done=1, Zero=0, Carry=0.
- SUB edge cases:
  - A=3, B=3 → BusW=0, Zero=1, Carry=1, Overflow=0.
  - A=0, B=1 → BusW=all ones, Negative=1, Carry=0.
  - A=0x8000_0000_0000_0000, B=1 → BusW=0x7FFF_FFFF_FFFF_FFFF, Overflow=1.
- Shifts:
  - LSL A=1, B=63 → BusW=0x8000_0000_0000_0000, Negative=1.
  - LSR with B=64 → 0.
  - ASR A=0x8000_0000_0000_0000, B=70 → all ones.
  - ASR with B=4 → 0xF800_0000_0000_0000.
- MUL A=0x1_0000_0001, B=0x3:
  - Busy=1 for 64 cycles, then BusW=0x3_0000_0003 with Done=1 for one cycle.
  - Start pulsed at cycle 10 of the multiply → ignored; exactly one Done.
- MUL wrap: A=2^63, B=2 → BusW=0, Zero=1, Carry=0. Resetb pulsed low at cycle 30 of a second MUL → no Done, Busy=0, BusW=0.
- Handshake and flag hold:
  - Undefined code 1111 → BusW=0, Done pulses.
  - Start held high with ADD then PassB B=0xAB on consecutive cycles → two consecutive Done pulses with BusW=sum, then 0xAB.
  - Flags unchanged on idle cycles.
